// File: rtl/dadd_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : dadd_burst_gen
// Description : Generates a burst of beats. Each beat carries incrementing
//               data (seed + k*data_incr) and an incrementing address
//               (base_addr + k*bytes-per-beat). Supports abort, a one-cycle
//               done pulse on normal completion, and, when the macro
//               DADD_GEN_GAP_EN is defined, programmable idle gaps between
//               beats.
// Options     : DADD_GEN_GAP_EN - adds the gap_cycles port and the GAP state.
// Revision    : 1.0 - initial release
// ============================================================================
module dadd_burst_gen #(
    parameter int LOC_AWIDTH = 32,
    parameter int LOC_DWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LOC_AWIDTH-1:0] base_addr,
    input  logic [15:0]           burst_len,
    input  logic [LOC_DWIDTH-1:0] seed,
    input  logic [7:0]            data_incr,
`ifdef DADD_GEN_GAP_EN
    input  logic [3:0]            gap_cycles,
`endif
    output logic                  dadd_in_en,
    output logic [LOC_DWIDTH-1:0] dadd_in,
    output logic [LOC_AWIDTH-1:0] dadd_in_addr,
    output logic                  busy,
    output logic                  done
);

    // Address advance per beat: one beat is LOC_DWIDTH/8 bytes wide.
    localparam logic [LOC_AWIDTH-1:0] c_addr_step = LOC_AWIDTH'(LOC_DWIDTH / 8);

    // The state names the cycle currently being presented on the outputs:
    // SEND means a beat is on the bus right now.
`ifdef DADD_GEN_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic                    en_q, en_d;
    logic [LOC_DWIDTH-1:0]   data_q, data_d;
    logic [LOC_AWIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              incr_q, incr_d;
    logic [15:0]             left_q, left_d;     // beats remaining, including the one on the bus
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
`ifdef DADD_GEN_GAP_EN
    logic [3:0]              gap_q, gap_d;       // latched gap length
    logic [3:0]              gcnt_q, gcnt_d;     // idle cycles left in the current gap
`endif

    logic                    w_next_beat;
    logic [LOC_DWIDTH-1:0]   w_data_next;
    logic [LOC_AWIDTH-1:0]   w_addr_next;

    // Following beat is derived from the beat last presented; the output
    // registers hold between beats so they double as the running values.
    assign w_data_next = data_q + LOC_DWIDTH'(incr_q);
    assign w_addr_next = addr_q + c_addr_step;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            incr_q  <= '0;
            left_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DADD_GEN_GAP_EN
            gap_q   <= '0;
            gcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            incr_q  <= incr_d;
            left_q  <= left_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DADD_GEN_GAP_EN
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
`endif
        end
    end

    // Next-state and next-output decode; outputs follow the next state so
    // they are registered yet line up with it.
    always_comb begin
        state_d     = state_q;
        en_d        = 1'b0;
        data_d      = data_q;
        addr_d      = addr_q;
        incr_d      = incr_q;
        left_d      = left_q;
        w_next_beat = 1'b0;
`ifdef DADD_GEN_GAP_EN
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Abort has priority over a simultaneous start.
                if (start && !abort) begin
                    incr_d = data_incr;
                    left_d = burst_len;
`ifdef DADD_GEN_GAP_EN
                    gap_d  = gap_cycles;
`endif
                    if (burst_len == 16'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SEND;
                        en_d    = 1'b1;
                        data_d  = seed;
                        addr_d  = base_addr;
                    end
                end
            end

            ST_SEND: begin
                // The beat already on the bus completes; abort only stops
                // the ones that would follow.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (left_q == 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    left_d = left_q - 16'd1;
`ifdef DADD_GEN_GAP_EN
                    if (gap_q != 4'd0) begin
                        state_d = ST_GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        w_next_beat = 1'b1;
                    end
`else
                    w_next_beat = 1'b1;
`endif
                end
            end

`ifdef DADD_GEN_GAP_EN
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q == 4'd1) begin
                    w_next_beat = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_next_beat) begin
            state_d = ST_SEND;
            en_d    = 1'b1;
            data_d  = w_data_next;
            addr_d  = w_addr_next;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign dadd_in_en   = en_q;
    assign dadd_in      = data_q;
    assign dadd_in_addr = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dadd_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadd_burst_gen
// Description : Self-checking bench for dadd_burst_gen. Expected per-cycle
//               output timelines are built from the burst rules with plain
//               arithmetic and compared cycle by cycle.
// Options     : DADD_GEN_GAP_EN - when defined, gap_cycles is driven and
//               expected gaps are inserted between beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dadd_burst_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [15:0] burst_len;
    logic [31:0] seed;
    logic [7:0]  data_incr;
`ifdef DADD_GEN_GAP_EN
    logic [3:0]  gap_cycles;
`endif
    logic        dadd_in_en;
    logic [31:0] dadd_in;
    logic [31:0] dadd_in_addr;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;

    // Values the outputs are expected to hold while no beat is driven.
    logic [31:0] hold_d = 32'd0;
    logic [31:0] hold_a = 32'd0;

    always #5 clk = ~clk;

    dadd_burst_gen #(
        .LOC_AWIDTH(32),
        .LOC_DWIDTH(32)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .burst_len    (burst_len),
        .seed         (seed),
        .data_incr    (data_incr),
`ifdef DADD_GEN_GAP_EN
        .gap_cycles   (gap_cycles),
`endif
        .dadd_in_en   (dadd_in_en),
        .dadd_in      (dadd_in),
        .dadd_in_addr (dadd_in_addr),
        .busy         (busy),
        .done         (done)
    );

    task automatic scramble_config();
        base_addr = $urandom;
        burst_len = 16'($urandom);
        seed      = $urandom;
        data_incr = 8'($urandom);
`ifdef DADD_GEN_GAP_EN
        gap_cycles = 4'($urandom);
`endif
    endtask

    // Launch one burst and compare every cycle against a timeline built from
    // the burst rules. abort_beat (1-based) aborts during that beat; 0 = none.
    task automatic run_burst(input logic [31:0] base, input logic [15:0] len,
                             input logic [31:0] sd, input logic [7:0] inc,
                             input logic [3:0] gp, input int abort_beat,
                             input string name);
        logic        q_en[$];
        logic        q_busy[$];
        logic        q_done[$];
        logic [31:0] q_d[$];
        logic [31:0] q_a[$];
        logic [3:0]  g;
        logic [31:0] d;
        logic [31:0] a;
        int          abort_idx;
        logic [66:0] got;
        logic [66:0] exp;
`ifdef DADD_GEN_GAP_EN
        g = gp;
`else
        g = gp & 4'h0;   // no gaps exist without the gap feature
`endif
        abort_idx = -1;
        for (int k = 0; k < int'(len); k++) begin
            d = sd + 32'(k) * {24'd0, inc};
            a = base + 32'(k) * 32'd4;
            q_en.push_back(1'b1); q_busy.push_back(1'b1); q_done.push_back(1'b0);
            q_d.push_back(d); q_a.push_back(a);
            hold_d = d;
            hold_a = a;
            if (abort_beat == k + 1) begin
                abort_idx = q_en.size() - 1;
                break;
            end
            if (k != int'(len) - 1) begin
                for (int j = 0; j < int'(g); j++) begin
                    q_en.push_back(1'b0); q_busy.push_back(1'b1); q_done.push_back(1'b0);
                    q_d.push_back(hold_d); q_a.push_back(hold_a);
                end
            end
        end
        if (abort_idx < 0) begin
            q_en.push_back(1'b0); q_busy.push_back(1'b1); q_done.push_back(1'b1);
            q_d.push_back(hold_d); q_a.push_back(hold_a);
        end
        for (int j = 0; j < 2; j++) begin
            q_en.push_back(1'b0); q_busy.push_back(1'b0); q_done.push_back(1'b0);
            q_d.push_back(hold_d); q_a.push_back(hold_a);
        end

        @(posedge clk); #1;
        base_addr = base; burst_len = len; seed = sd; data_incr = inc;
`ifdef DADD_GEN_GAP_EN
        gap_cycles = gp;
`endif
        start = 1'b1;
        abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_config();

        for (int i = 0; i < q_en.size(); i++) begin
            @(negedge clk);
            got = {dadd_in_en, busy, done, dadd_in, dadd_in_addr};
            exp = {q_en[i], q_busy[i], q_done[i], q_d[i], q_a[i]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got en=%b busy=%b done=%b data=%h addr=%h, expected en=%b busy=%b done=%b data=%h addr=%h",
                         name, i, dadd_in_en, busy, done, dadd_in, dadd_in_addr,
                         q_en[i], q_busy[i], q_done[i], q_d[i], q_a[i]);
            end
            // While a burst is owned, extra starts and config churn must be ignored.
            abort = (i == abort_idx);
            if (q_busy[i]) begin
                start = 1'($urandom);
                scramble_config();
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        scramble_config();
        #3;
        checks++;
        if ({dadd_in_en, busy, done, dadd_in, dadd_in_addr} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state: got en=%b busy=%b done=%b data=%h addr=%h, expected all zero",
                     dadd_in_en, busy, done, dadd_in, dadd_in_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        hold_d = 32'd0; hold_a = 32'd0;
    endtask

    task automatic test_basic();
        run_burst(32'h100, 16'd4, 32'h10, 8'd3, 4'd0, 0, "basic");
    endtask

    task automatic test_zero_len();
        run_burst(32'h2000, 16'd0, 32'h55, 8'd7, 4'd3, 0, "zero_len");
    endtask

    task automatic test_gap();
        run_burst(32'h40, 16'd3, 32'h1, 8'd2, 4'd2, 0, "gap");
    endtask

    task automatic test_wrap();
        run_burst(32'hFFFF_FFFC, 16'd3, 32'hFFFF_FFFE, 8'd1, 4'd0, 0, "wrap");
    endtask

    task automatic test_abort();
        run_burst(32'h800, 16'd8, 32'hA0, 8'd5, 4'd0, 2, "abort");
    endtask

    task automatic test_abort_start_idle();
        @(posedge clk); #1;
        base_addr = 32'h300; burst_len = 16'd3; seed = 32'h9; data_incr = 8'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({dadd_in_en, busy, done, dadd_in, dadd_in_addr} !== {3'b000, hold_d, hold_a}) begin
                errors++;
                $display("FAIL abort_start_idle cycle %0d: got en=%b busy=%b done=%b data=%h addr=%h, expected idle with data=%h addr=%h",
                         i, dadd_in_en, busy, done, dadd_in, dadd_in_addr, hold_d, hold_a);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        @(posedge clk); #1;
        base_addr = 32'h5000; burst_len = 16'd8; seed = 32'h77; data_incr = 8'd9;
`ifdef DADD_GEN_GAP_EN
        gap_cycles = 4'd0;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dadd_in_en, busy, done, dadd_in, dadd_in_addr} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got en=%b busy=%b done=%b data=%h addr=%h, expected all zero",
                     dadd_in_en, busy, done, dadd_in, dadd_in_addr);
        end
        @(posedge clk); #1;
        checks++;
        if ({dadd_in_en, busy, done, dadd_in, dadd_in_addr} !== 67'd0) begin
            errors++;
            $display("FAIL reset_mid_held: got en=%b busy=%b done=%b data=%h addr=%h, expected all zero",
                     dadd_in_en, busy, done, dadd_in, dadd_in_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        hold_d = 32'd0; hold_a = 32'd0;
        run_burst(32'h6000, 16'd3, 32'h1234, 8'd16, 4'd1, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] len;
        int          ab;
        for (int n = 0; n < 20; n++) begin
            len = 16'($urandom_range(0, 6));
            ab  = 0;
            if (len != 16'd0 && $urandom_range(0, 9) < 3)
                ab = $urandom_range(1, int'(len));
            run_burst($urandom, len, $urandom, 8'($urandom), 4'($urandom_range(0, 3)),
                      ab, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_burst(32'hA000, 16'd2, 32'hF0, 8'd255, 4'd0, 0, "b2b_first");
        run_burst(32'hB000, 16'd5, 32'h0, 8'd128, 4'd0, 0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_gap();
        test_wrap();
        test_abort();
        test_abort_start_idle();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
